psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: psum_collector

---
 rtl/psum_collector.sv | 58 +++++
 tb/tb_psum_collector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/psum_collector.sv
// psum_collector: per-column first-word-fall-through FIFOs that regroup staggered MAC-row psums into whole rows
// clk: rising-edge clock; reset: asynchronous, active-low
// in/wr: per-column psum and write strobe; rd: pop one full row from every column
// out: head entry of each column; o_valid: every column holds data; o_full: some column full; o_ready: !o_full
// err_ovf: sticky, a write hit a full column; err_udf: sticky, rd issued with no full row available
module psum_collector #(
  parameter int psum_bw = 16,
  parameter int col = 8,
  parameter int depth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   err_ovf,
  output logic                   err_udf
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] one = 1;
  logic [col-1:0] full, empty;
  logic pop;
  assign o_valid = ~|empty;
  assign o_full = |full;
  assign o_ready = ~o_full;
  assign pop = rd & o_valid;
  for (genvar j = 0; j < col; j++) begin : g_col
    logic [aw:0] wp, rp;
    logic [psum_bw-1:0] mem [depth];
    logic we;
    assign full[j] = (wp[aw-1:0] == rp[aw-1:0]) && (wp[aw] != rp[aw]);
    assign empty[j] = wp == rp;
    assign we = wr[j] & ~full[j];
    assign out[psum_bw*j +: psum_bw] = mem[rp[aw-1:0]];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
      end else begin
        if (we) wp <= wp + one;
        if (pop) rp <= rp + one;
      end
    always_ff @(posedge clk)
      if (reset && we) mem[wp[aw-1:0]] <= in[psum_bw*j +: psum_bw];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (|(wr & full)) err_ovf <= 1'b1;
      if (rd && !o_valid) err_udf <= 1'b1;
    end
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed bench with a queue-based row model checked every cycle
module tb_psum_collector;
  localparam int pb = 16;
  localparam int c = 8;
  localparam int d = 8;
  logic clk = 0;
  logic reset = 0;
  logic [pb*c-1:0] in = '0;
  logic [c-1:0] wr = '0;
  logic rd = 0;
  logic [pb*c-1:0] out;
  logic o_valid, o_full, o_ready, err_ovf, err_udf;
  int n_chk = 0;
  int n_fail = 0;
  logic [pb-1:0] q [c][$];
  logic m_ovf = 0;
  logic m_udf = 0;
  psum_collector #(.psum_bw(pb), .col(c), .depth(d)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready),
    .err_ovf(err_ovf), .err_udf(err_udf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [pb*c-1:0] act, input logic [pb*c-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [pb*c-1:0] row(input int base);
    logic [pb*c-1:0] r;
    for (int j = 0; j < c; j++) r[pb*j +: pb] = pb'(base + j);
    return r;
  endfunction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < c; j++) q[j].delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      logic v;
      logic [c-1:0] f;
      v = 1;
      for (int j = 0; j < c; j++) begin
        if (q[j].size() == 0) v = 0;
        f[j] = q[j].size() == d;
      end
      if (rd && !v) m_udf = 1;
      for (int j = 0; j < c; j++)
        if (wr[j]) begin
          if (f[j]) m_ovf = 1;
          else q[j].push_back(in[pb*j +: pb]);
        end
      if (rd && v) for (int j = 0; j < c; j++) void'(q[j].pop_front());
    end
  end
  always @(negedge clk) begin
    logic v, f;
    if (reset) begin
      v = 1;
      f = 0;
      for (int j = 0; j < c; j++) begin
        if (q[j].size() == 0) v = 0;
        if (q[j].size() == d) f = 1;
      end
      chk("o_valid", o_valid, v);
      chk("o_full", o_full, f);
      chk("o_ready", o_ready, !f);
      chk("err_ovf", err_ovf, m_ovf);
      chk("err_udf", err_udf, m_udf);
      if (v) for (int j = 0; j < c; j++) chk("out", out[pb*j +: pb], q[j][0]);
    end
  end
  task automatic step(input logic [c-1:0] w, input logic r, input logic [pb*c-1:0] dat);
    wr = w;
    rd = r;
    in = dat;
    @(posedge clk);
    #1;
    wr = '0;
    rd = 0;
  endtask
  task automatic do_reset();
    reset = 0;
    step('0, 0, '0);
    step('0, 0, '0);
    reset = 1;
  endtask
  initial begin
    step('0, 0, '0);
    chk("rst_valid", o_valid, 0);
    chk("rst_full", o_full, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_ovf", err_ovf, 0);
    chk("rst_udf", err_udf, 0);
    reset = 1;
    step('0, 1, '0);
    chk("udf_flag", err_udf, 1);
    chk("udf_valid", o_valid, 0);
    step('1, 0, row('h55));
    chk("udf_next_valid", o_valid, 1);
    chk("udf_next_out", out[pb-1:0], 16'h0055);
    do_reset();
    for (int j = 0; j < c; j++) begin
      chk("stag_not_valid", o_valid, 0);
      step(c'(1) << j, 0, row('h100));
    end
    chk("stag_valid", o_valid, 1);
    for (int j = 0; j < c; j++) chk("stag_out", out[pb*j +: pb], pb'(16'h100 + j));
    step('0, 1, '0);
    chk("stag_drained", o_valid, 0);
    do_reset();
    for (int r = 0; r < d; r++) step('1, 0, row('h200 + 16 * r));
    chk("full_flag", o_full, 1);
    chk("full_ready", o_ready, 0);
    chk("full_no_ovf", err_ovf, 0);
    step('1, 0, {c{16'hdead}});
    chk("ovf_flag", err_ovf, 1);
    for (int r = 0; r < d; r++) begin
      chk("ovf_order", out[pb*3 +: pb], pb'(16'h203 + 16 * r));
      step('0, 1, '0);
    end
    chk("ovf_drained", o_valid, 0);
    chk("ovf_sticky", err_ovf, 1);
    do_reset();
    for (int r = 0; r < d; r++) step('1, 0, row('h500 + 16 * r));
    step('1, 1, row('heee));
    chk("fwr_ovf", err_ovf, 1);
    chk("fwr_not_full", o_full, 0);
    chk("fwr_head", out[pb-1:0], 16'h0510);
    for (int r = 1; r < d; r++) begin
      chk("fwr_order", out[pb*7 +: pb], pb'(16'h507 + 16 * r));
      step('0, 1, '0);
    end
    chk("fwr_empty", o_valid, 0);
    do_reset();
    for (int r = 0; r < 3; r++) step('1, 0, row('h300 + 16 * r));
    for (int r = 3; r < 23; r++) step('1, 1, row('h300 + 16 * r));
    chk("conc_head", out[pb-1:0], 16'h0440);
    chk("conc_valid", o_valid, 1);
    chk("conc_not_full", o_full, 0);
    for (int r = 20; r < 23; r++) begin
      chk("conc_order", out[pb*5 +: pb], pb'(16'h305 + 16 * r));
      step('0, 1, '0);
    end
    chk("conc_occ3", o_valid, 0);
    do_reset();
    step('0, 1, '0);
    for (int r = 0; r < d; r++) step('1, 0, row('h600 + 16 * r));
    step('1, 0, row('hbad));
    for (int r = 0; r < 3; r++) step('0, 1, '0);
    chk("pre_ar_valid", o_valid, 1);
    chk("pre_ar_ovf", err_ovf, 1);
    chk("pre_ar_udf", err_udf, 1);
    @(negedge clk);
    #2;
    reset = 0;
    #1;
    chk("ar_valid", o_valid, 0);
    chk("ar_ovf", err_ovf, 0);
    chk("ar_udf", err_udf, 0);
    chk("ar_ready", o_ready, 1);
    step('1, 1, row('h999));
    step('1, 1, row('h999));
    chk("ar_ignored_valid", o_valid, 0);
    chk("ar_ignored_udf", err_udf, 0);
    reset = 1;
    step('1, 0, row('h700));
    chk("post_ar_valid", o_valid, 1);
    chk("post_ar_out", out[pb*2 +: pb], 16'h0702);
    chk("post_ar_ovf", err_ovf, 0);
    step('0, 1, '0);
    step('0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
